// File: rtl/riscvlong_mem_arbiter_if.sv
// Bus bundle between the core's I/D memory ports, the arbiter and the unified memory port.
// The arbiter uses the slave view; whatever drives the core and memory sides uses master.
interface riscvlong_mem_arbiter_if #(
  parameter int REQ_SZ  = 67,
  parameter int RESP_SZ = 35
);
  logic [REQ_SZ-1:0]  imemreq_msg;
  logic               imemreq_val;
  logic               imemreq_rdy;
  logic [RESP_SZ-1:0] imemresp_msg;
  logic               imemresp_val;
  logic [REQ_SZ-1:0]  dmemreq_msg;
  logic               dmemreq_val;
  logic               dmemreq_rdy;
  logic [RESP_SZ-1:0] dmemresp_msg;
  logic               dmemresp_val;
  logic [REQ_SZ-1:0]  memreq_msg;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [RESP_SZ-1:0] memresp_msg;
  logic               memresp_val;

  // A request transfers on a cycle where both val and rdy are high.
  // val must not wait on rdy. Responses carry no rdy and are consumed when val is high.
  modport slave (
    input  imemreq_msg, imemreq_val, dmemreq_msg, dmemreq_val,
    input  memreq_rdy, memresp_msg, memresp_val,
    output imemreq_rdy, imemresp_msg, imemresp_val,
    output dmemreq_rdy, dmemresp_msg, dmemresp_val,
    output memreq_msg, memreq_val
  );

  modport master (
    output imemreq_msg, imemreq_val, dmemreq_msg, dmemreq_val,
    output memreq_rdy, memresp_msg, memresp_val,
    input  imemreq_rdy, imemresp_msg, imemresp_val,
    input  dmemreq_rdy, dmemresp_msg, dmemresp_val,
    input  memreq_msg, memreq_val
  );
endinterface

// File: rtl/riscvlong_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction and data requests.
// A tag FIFO records the source of each in-flight request, so in-order responses go back to the right port.
module riscvlong_mem_arbiter #(
  parameter int REQ_SZ  = 67,
  parameter int RESP_SZ = 35,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  riscvlong_mem_arbiter_if.slave    bus,
  output logic [PTR_W:0]            outstanding,
  output logic                      err
);
  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  src_e             tag_q [DEPTH];
  src_e             tag_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             err_q, err_d;
  src_e             last_grant_q, last_grant_d;
  logic             lock_val_q, lock_val_d;
  src_e             lock_src_q, lock_src_d;

  logic               full, empty, fire, pop;
  src_e               grant, head_tag;
  logic [REQ_SZ-1:0]  granted_msg;
  logic [RESP_SZ-1:0] resp_msg;

  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_tag = tag_q[rd_ptr_q];

  // A stalled winner keeps the grant until accepted so the memory sees a stable message.
  always_comb begin
    grant = SRC_I;
    if (lock_val_q)
      grant = lock_src_q;
    else if (bus.imemreq_val && !bus.dmemreq_val)
      grant = SRC_I;
    else if (!bus.imemreq_val && bus.dmemreq_val)
      grant = SRC_D;
    else if (bus.imemreq_val && bus.dmemreq_val)
      grant = (last_grant_q == SRC_I) ? SRC_D : SRC_I;
  end

  assign granted_msg     = (grant == SRC_D) ? bus.dmemreq_msg : bus.imemreq_msg;
  assign bus.memreq_msg  = granted_msg;
  assign bus.memreq_val  = (bus.imemreq_val | bus.dmemreq_val) & ~full & ~reset;
  assign bus.imemreq_rdy = bus.memreq_rdy & ~full & (grant == SRC_I) & bus.imemreq_val & ~reset;
  assign bus.dmemreq_rdy = bus.memreq_rdy & ~full & (grant == SRC_D) & bus.dmemreq_val & ~reset;
  assign fire            = bus.memreq_val & bus.memreq_rdy;

  assign pop              = bus.memresp_val & ~empty & ~reset;
  assign resp_msg         = bus.memresp_msg;
  assign bus.imemresp_msg = resp_msg;
  assign bus.dmemresp_msg = resp_msg;
  assign bus.imemresp_val = pop & (head_tag == SRC_I);
  assign bus.dmemresp_val = pop & (head_tag == SRC_D);

  assign outstanding = cnt_q;
  assign err         = err_q;

  always_comb begin
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    lock_val_d   = lock_val_q;
    lock_src_d   = lock_src_q;
    err_d        = err_q | (bus.memresp_val & empty);
    if (fire) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      last_grant_d    = grant;
      lock_val_d      = 1'b0;
    end else if (bus.memreq_val) begin
      lock_val_d = 1'b1;
      lock_src_d = grant;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fire, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= SRC_I;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      last_grant_q <= SRC_D;
      lock_val_q   <= 1'b0;
      lock_src_q   <= SRC_I;
    end else begin
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      lock_val_q   <= lock_val_d;
      lock_src_q   <= lock_src_d;
    end
  end
endmodule

// File: tb/tb_riscvlong_mem_arbiter.sv
// Directed bench for riscvlong_mem_arbiter: a queue-based memory model answers fired requests,
// and expected responses are queued per port when the matching request is driven.
module tb_riscvlong_mem_arbiter;
  localparam int REQ_SZ  = 67;
  localparam int RESP_SZ = 35;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscvlong_mem_arbiter_if #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ)) bus ();
  logic [PTR_W:0] outstanding;
  logic           err;

  riscvlong_mem_arbiter #(
    .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .outstanding(outstanding),
    .err(err)
  );

  // scoreboard
  logic [RESP_SZ-1:0] exp_i_q[$];
  logic [RESP_SZ-1:0] exp_d_q[$];
  logic [REQ_SZ-1:0]  mem_q[$];
  bit                 resp_en;
  int                 n_cmp = 0;
  int                 n_err = 0;

  function automatic logic [REQ_SZ-1:0] mk_i(input int n);
    logic [31:0] nn;
    nn = n;
    return {3'b001, 32'h1000_0000 + nn, 32'hC0DE_0000 + nn};
  endfunction

  function automatic logic [REQ_SZ-1:0] mk_d(input int n);
    logic [31:0] nn;
    nn = n;
    return {3'b010, 32'h2000_0000 + nn, 32'hDA7A_0000 + nn};
  endfunction

  function automatic logic [RESP_SZ-1:0] resp_of(input logic [REQ_SZ-1:0] m);
    return {m[66:64], m[31:0] ^ 32'h5A5A_A5A5};
  endfunction

  task automatic chk(input string tag, input logic [REQ_SZ-1:0] obs, input logic [REQ_SZ-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [RESP_SZ-1:0] e;
    chk("resp_val_both", {66'd0, bus.imemresp_val & bus.dmemresp_val}, '0);
    if (bus.imemresp_val === 1'b1) begin
      if (exp_i_q.size() == 0) chk("imem_resp_unexpected", 1, 0);
      else begin
        e = exp_i_q.pop_front();
        chk("imem_resp_msg", bus.imemresp_msg, e);
      end
    end
    if (bus.dmemresp_val === 1'b1) begin
      if (exp_d_q.size() == 0) chk("dmem_resp_unexpected", 1, 0);
      else begin
        e = exp_d_q.pop_front();
        chk("dmem_resp_msg", bus.dmemresp_msg, e);
      end
    end
  endtask

  // driver tasks: inputs change #1 after posedge, outputs are checked at negedge
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    monitor();
    if (bus.memreq_val === 1'b1 && bus.memreq_rdy === 1'b1) mem_q.push_back(bus.memreq_msg);
    @(posedge clk);
    #1;
    if (resp_en && mem_q.size() > 0) begin
      bus.memresp_val = 1'b1;
      bus.memresp_msg = resp_of(mem_q.pop_front());
    end else begin
      bus.memresp_val = 1'b0;
    end
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drain(input int n);
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ii;
    int di;
    logic g;

    reset           = 1'b1;
    resp_en         = 1'b1;
    bus.imemreq_msg = mk_i(0);
    bus.dmemreq_msg = mk_d(0);
    bus.imemreq_val = 1'b1;
    bus.dmemreq_val = 1'b1;
    bus.memreq_rdy  = 1'b1;
    bus.memresp_val = 1'b0;
    bus.memresp_msg = '0;

    // reset gating
    settle();
    chk("rst_memreq_val", bus.memreq_val, 0);
    chk("rst_imemreq_rdy", bus.imemreq_rdy, 0);
    chk("rst_dmemreq_rdy", bus.dmemreq_rdy, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    step();

    // both requesters every cycle: I, D, I, D
    ii = 0;
    di = 0;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 1);
      bus.imemreq_val = 1'b1;
      bus.dmemreq_val = 1'b1;
      bus.imemreq_msg = mk_i(ii);
      bus.dmemreq_msg = mk_d(di);
      settle();
      chk("rr_memreq_msg", bus.memreq_msg, g ? mk_d(di) : mk_i(ii));
      chk("rr_imemreq_rdy", bus.imemreq_rdy, !g);
      chk("rr_dmemreq_rdy", bus.dmemreq_rdy, g);
      if (g) begin
        exp_d_q.push_back(resp_of(mk_d(di)));
        di++;
      end else begin
        exp_i_q.push_back(resp_of(mk_i(ii)));
        ii++;
      end
      advance();
    end
    drain(3);
    chk("rr_outstanding_done", outstanding, 0);

    // imem only for 3 cycles, responses one cycle later
    for (int k = 0; k < 3; k++) begin
      bus.imemreq_val = 1'b1;
      bus.imemreq_msg = mk_i(10 + k);
      settle();
      chk("i_memreq_msg", bus.memreq_msg, mk_i(10 + k));
      chk("i_imemreq_rdy", bus.imemreq_rdy, 1);
      chk("i_outstanding", outstanding, (k == 0) ? 0 : 1);
      exp_i_q.push_back(resp_of(mk_i(10 + k)));
      advance();
    end
    bus.imemreq_val = 1'b0;
    settle();
    chk("i_outstanding_tail", outstanding, 1);
    advance();
    drain(2);
    chk("i_outstanding_done", outstanding, 0);

    // stalled imem holds the grant while dmem arrives
    bus.memreq_rdy  = 1'b0;
    bus.imemreq_val = 1'b1;
    bus.imemreq_msg = mk_i(20);
    settle();
    chk("lk0_memreq_msg", bus.memreq_msg, mk_i(20));
    chk("lk0_imemreq_rdy", bus.imemreq_rdy, 0);
    advance();
    bus.dmemreq_val = 1'b1;
    bus.dmemreq_msg = mk_d(20);
    settle();
    chk("lk1_memreq_msg", bus.memreq_msg, mk_i(20));
    chk("lk1_dmemreq_rdy", bus.dmemreq_rdy, 0);
    advance();
    bus.memreq_rdy = 1'b1;
    settle();
    chk("lk2_memreq_msg", bus.memreq_msg, mk_i(20));
    chk("lk2_imemreq_rdy", bus.imemreq_rdy, 1);
    chk("lk2_dmemreq_rdy", bus.dmemreq_rdy, 0);
    exp_i_q.push_back(resp_of(mk_i(20)));
    advance();
    bus.imemreq_val = 1'b0;
    settle();
    chk("lk3_memreq_msg", bus.memreq_msg, mk_d(20));
    chk("lk3_dmemreq_rdy", bus.dmemreq_rdy, 1);
    exp_d_q.push_back(resp_of(mk_d(20)));
    advance();
    drain(3);

    // fill to DEPTH, then free one slot
    resp_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.dmemreq_val = 1'b1;
      bus.dmemreq_msg = mk_d(30 + k);
      settle();
      chk("fill_dmemreq_rdy", bus.dmemreq_rdy, 1);
      exp_d_q.push_back(resp_of(mk_d(30 + k)));
      advance();
    end
    bus.dmemreq_msg = mk_d(30 + DEPTH);
    settle();
    chk("full_outstanding", outstanding, DEPTH);
    chk("full_memreq_val", bus.memreq_val, 0);
    chk("full_dmemreq_rdy", bus.dmemreq_rdy, 0);
    chk("full_imemreq_rdy", bus.imemreq_rdy, 0);
    resp_en = 1'b1;
    advance();
    resp_en = 1'b0;
    settle();
    chk("full_pop_memreq_val", bus.memreq_val, 0);
    chk("full_pop_dmemreq_rdy", bus.dmemreq_rdy, 0);
    advance();
    settle();
    chk("after_pop_outstanding", outstanding, DEPTH - 1);
    chk("fifth_dmemreq_rdy", bus.dmemreq_rdy, 1);
    exp_d_q.push_back(resp_of(mk_d(30 + DEPTH)));
    advance();
    bus.dmemreq_val = 1'b0;
    settle();
    chk("refill_outstanding", outstanding, DEPTH);
    advance();
    resp_en = 1'b1;
    drain(6);
    chk("fill_outstanding_done", outstanding, 0);

    // response with empty FIFO
    chk("pre_stray_err", err, 0);
    mem_q.push_back(mk_d(99));
    step();
    settle();
    chk("stray_imemresp_val", bus.imemresp_val, 0);
    chk("stray_dmemresp_val", bus.dmemresp_val, 0);
    resp_en = 1'b0;
    advance();
    settle();
    chk("stray_err", err, 1);
    advance();
    drain(2);
    chk("stray_err_held", err, 1);

    // reset with two requests in flight, then late responses
    for (int k = 0; k < 2; k++) begin
      bus.imemreq_val = 1'b1;
      bus.imemreq_msg = mk_i(40 + k);
      step();
    end
    chk("pre_reset_outstanding", outstanding, 2);
    reset = 1'b1;
    #1;
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_memreq_val", bus.memreq_val, 0);
    chk("async_rst_imemreq_rdy", bus.imemreq_rdy, 0);
    step();
    reset           = 1'b0;
    bus.imemreq_val = 1'b0;
    resp_en         = 1'b1;
    step();
    settle();
    chk("late_imemresp_val", bus.imemresp_val, 0);
    chk("late_dmemresp_val", bus.dmemresp_val, 0);
    advance();
    settle();
    chk("late_err", err, 1);
    advance();
    drain(2);
    chk("late_outstanding", outstanding, 0);

    // final report
    chk("exp_i_left", exp_i_q.size(), 0);
    chk("exp_d_left", exp_d_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
